// File: rtl/spi_frame_tx.sv
// Serialises 16-bit pixel words MSB first onto a chip-select-less SPI link
// (mode 0, spi_clk idles low) and tracks word position within a panel frame.
module spi_frame_tx #(
  parameter int unsigned CLK_DIV         = 2,
  parameter int unsigned GAP_CYCLES      = 0,
  parameter int unsigned WORDS_PER_FRAME = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        busy,
  output logic        frame_done,
  output logic [10:0] word_count
);

  localparam logic [7:0]  DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0]  GAP_LOAD = 8'(GAP_CYCLES - 1);
  localparam logic [10:0] WC_LAST  = 11'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LOW, SHIFT_HIGH, GAP} state_t;

  state_t      state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        spi_clk_q, spi_clk_d;
  logic        spi_mosi_q, spi_mosi_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic [10:0] word_count_q, word_count_d;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    div_cnt_d    = div_cnt_q;
    spi_clk_d    = spi_clk_q;
    spi_mosi_d   = spi_mosi_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    word_count_d = word_count_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d    = in_data;
          bit_cnt_d  = 4'd15;
          spi_mosi_d = in_data[15];
          spi_clk_d  = 1'b0;
          div_cnt_d  = DIV_LOAD;
          busy_d     = 1'b1;
          state_d    = SHIFT_LOW;
        end
      end
      SHIFT_LOW: begin
        if (div_cnt_q == 8'd0) begin
          spi_clk_d = 1'b1;
          div_cnt_d = DIV_LOAD;
          state_d   = SHIFT_HIGH;
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end
      SHIFT_HIGH: begin
        if (div_cnt_q == 8'd0) begin
          spi_clk_d = 1'b0;
          if (bit_cnt_q != 4'd0) begin
            // Next bit is launched on the falling edge so it is settled well before the next rise.
            bit_cnt_d  = bit_cnt_q - 4'd1;
            shreg_d    = shreg_q << 1;
            spi_mosi_d = shreg_q[14];
            div_cnt_d  = DIV_LOAD;
            state_d    = SHIFT_LOW;
          end else begin
            spi_mosi_d = 1'b0;
            if (word_count_q == WC_LAST) begin
              word_count_d = 11'd0;
              frame_done_d = 1'b1;
            end else begin
              word_count_d = word_count_q + 11'd1;
            end
            if (GAP_CYCLES != 0) begin
              div_cnt_d = GAP_LOAD;
              state_d   = GAP;
            end else begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (div_cnt_q == 8'd0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= 16'd0;
      bit_cnt_q    <= 4'd0;
      div_cnt_q    <= 8'd0;
      spi_clk_q    <= 1'b0;
      spi_mosi_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      word_count_q <= 11'd0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      spi_clk_q    <= spi_clk_d;
      spi_mosi_q   <= spi_mosi_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      word_count_q <= word_count_d;
    end
  end

  // Ready drops immediately with reset so nothing is accepted into a block being cleared.
  assign in_ready   = (state_q == IDLE) && !reset;
  assign spi_clk    = spi_clk_q;
  assign spi_mosi   = spi_mosi_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Directed bench for spi_frame_tx: three instances cover the default timing,
// a CLK_DIV=1/GAP_CYCLES=3 variant, and a fast full-frame run.
module tb_spi_frame_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] a_data, b_data, c_data;
  logic        a_valid, b_valid, c_valid;
  logic        a_ready, a_sclk, a_mosi, a_busy, a_fd;
  logic        b_ready, b_sclk, b_mosi, b_busy, b_fd;
  logic        c_ready, c_sclk, c_mosi, c_busy, c_fd;
  logic [10:0] a_wc, b_wc, c_wc;

  spi_frame_tx #(.CLK_DIV(2), .GAP_CYCLES(0), .WORDS_PER_FRAME(2048)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .spi_clk(a_sclk), .spi_mosi(a_mosi), .busy(a_busy), .frame_done(a_fd), .word_count(a_wc));

  spi_frame_tx #(.CLK_DIV(1), .GAP_CYCLES(3), .WORDS_PER_FRAME(2048)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .spi_clk(b_sclk), .spi_mosi(b_mosi), .busy(b_busy), .frame_done(b_fd), .word_count(b_wc));

  spi_frame_tx #(.CLK_DIV(1), .GAP_CYCLES(0), .WORDS_PER_FRAME(2048)) dut_c (
    .clk(clk), .reset(reset), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .spi_clk(c_sclk), .spi_mosi(c_mosi), .busy(c_busy), .frame_done(c_fd), .word_count(c_wc));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One word on instance A, then observe 70 cycles of the line.
  task automatic send_a(input logic [15:0] w, output logic [15:0] bits, output int rises,
                        output int busy_cyc, output int bad_mosi, output int fd_cnt);
    logic prev_sclk, prev_mosi;
    bits = '0; rises = 0; busy_cyc = 0; bad_mosi = 0; fd_cnt = 0;
    @(negedge clk); a_data = w; a_valid = 1'b1;
    @(negedge clk); a_valid = 1'b0; a_data = 16'hDEAD;
    prev_sclk = 1'b0; prev_mosi = a_mosi;
    for (int i = 0; i < 70; i++) begin
      if (i > 0) @(negedge clk);
      if (a_sclk && !prev_sclk) begin bits = {bits[14:0], a_mosi}; rises++; end
      if (a_sclk && i > 0 && a_mosi !== prev_mosi) bad_mosi++;
      if (a_busy) busy_cyc++;
      if (a_fd) fd_cnt++;
      prev_sclk = a_sclk; prev_mosi = a_mosi;
    end
  endtask

  logic [15:0] bits16;
  logic [47:0] bits48;
  logic [31:0] bits32;
  int rises, busy_cyc, bad_mosi, fd_cnt, edges, notready, nacc;
  int acc_cyc[3];
  int acc_wc[3];
  int rise_cyc[2];
  logic [15:0] words[3];
  logic prev_sclk, just, done;
  int npulse, pulse_nacc, pulse_wc, pulse_prev_wc, prev_wc;
  logic pulse_prev_sclk, pulse_sclk;

  initial begin
    reset = 1'b1;
    a_data = '0; a_valid = 1'b0;
    b_data = '0; b_valid = 1'b0;
    c_data = '0; c_valid = 1'b0;

    // Reset state and idle line
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(a_ready), 64'(0));
    check("rst_sclk",  64'(a_sclk),  64'(0));
    check("rst_mosi",  64'(a_mosi),  64'(0));
    check("rst_busy",  64'(a_busy),  64'(0));
    check("rst_fd",    64'(a_fd),    64'(0));
    check("rst_wc",    64'(a_wc),    64'(0));
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_release", 64'(a_ready), 64'(1));
    edges = 0; busy_cyc = 0; notready = 0; prev_sclk = a_sclk;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (a_sclk !== prev_sclk) edges++;
      if (a_busy) busy_cyc++;
      if (!a_ready) notready++;
      prev_sclk = a_sclk;
    end
    check("idle_edges", 64'(edges), 64'(0));
    check("idle_busy", 64'(busy_cyc), 64'(0));
    check("idle_notready", 64'(notready), 64'(0));

    // Single word 0xA5F0
    send_a(16'hA5F0, bits16, rises, busy_cyc, bad_mosi, fd_cnt);
    check("w1_bits", 64'(bits16), 64'(16'hA5F0));
    check("w1_rises", 64'(rises), 64'(16));
    check("w1_busy", 64'(busy_cyc), 64'(64));
    check("w1_mosi_stable", 64'(bad_mosi), 64'(0));
    check("w1_no_fd", 64'(fd_cnt), 64'(0));
    check("w1_wc", 64'(a_wc), 64'(1));
    check("w1_end_sclk", 64'(a_sclk), 64'(0));
    check("w1_end_mosi", 64'(a_mosi), 64'(0));

    // Reset during SHIFT_HIGH of bit 7 (9th rising edge)
    @(negedge clk); a_data = 16'hFFFF; a_valid = 1'b1;
    @(negedge clk); a_valid = 1'b0;
    rises = 0; prev_sclk = 1'b0;
    for (int i = 0; i < 200 && rises < 9; i++) begin
      @(negedge clk);
      if (a_sclk && !prev_sclk) rises++;
      prev_sclk = a_sclk;
    end
    check("mid_rises", 64'(rises), 64'(9));
    check("mid_sclk", 64'(a_sclk), 64'(1));
    check("mid_mosi", 64'(a_mosi), 64'(1));
    check("mid_wc", 64'(a_wc), 64'(1));
    #1 reset = 1'b1;
    #1;
    check("async_sclk", 64'(a_sclk), 64'(0));
    check("async_mosi", 64'(a_mosi), 64'(0));
    check("async_busy", 64'(a_busy), 64'(0));
    check("async_wc", 64'(a_wc), 64'(0));
    check("async_ready", 64'(a_ready), 64'(0));
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_midreset", 64'(a_ready), 64'(1));
    send_a(16'h6C3A, bits16, rises, busy_cyc, bad_mosi, fd_cnt);
    check("post_rst_bits", 64'(bits16), 64'(16'h6C3A));
    check("post_rst_rises", 64'(rises), 64'(16));
    check("post_rst_wc", 64'(a_wc), 64'(1));

    // Back-to-back words with in_valid held high
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    acc_cyc = '{0, 0, 0}; acc_wc = '{0, 0, 0};
    @(negedge clk); a_data = words[0]; a_valid = 1'b1;
    nacc = 0; just = 1'b0; bits48 = '0; rises = 0; prev_sclk = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      if (just) begin
        just = 1'b0;
        if (nacc >= 3) begin a_valid = 1'b0; a_data = 16'h0000; end
        else a_data = words[nacc];
      end
      if (a_sclk && !prev_sclk) begin bits48 = {bits48[46:0], a_mosi}; rises++; end
      prev_sclk = a_sclk;
      if (a_ready && a_valid) begin
        if (nacc < 3) begin acc_cyc[nacc] = c; acc_wc[nacc] = int'(a_wc); end
        nacc++; just = 1'b1;
      end
    end
    check("b2b_accepts", 64'(nacc), 64'(3));
    check("b2b_space01", 64'(acc_cyc[1] - acc_cyc[0]), 64'(65));
    check("b2b_space12", 64'(acc_cyc[2] - acc_cyc[1]), 64'(65));
    check("b2b_bits", 64'(bits48), 64'(48'h1111_2222_3333));
    check("b2b_rises", 64'(rises), 64'(48));
    check("b2b_wc_at_2nd", 64'(acc_wc[1]), 64'(1));
    check("b2b_wc_at_3rd", 64'(acc_wc[2]), 64'(2));
    check("b2b_wc_final", 64'(a_wc), 64'(3));

    // CLK_DIV=1, GAP_CYCLES=3 instance, two words back to back
    @(negedge clk); b_data = 16'hC3A5; b_valid = 1'b1;
    nacc = 0; just = 1'b0; bits32 = '0; rises = 0; busy_cyc = 0; prev_sclk = 1'b0;
    acc_cyc = '{0, 0, 0}; rise_cyc = '{0, 0};
    for (int c = 0; c < 100; c++) begin
      if (c > 0) @(negedge clk);
      if (just) begin
        just = 1'b0;
        if (nacc >= 2) b_valid = 1'b0;
        else b_data = 16'h5A3C;
      end
      if (b_sclk && !prev_sclk) begin
        if (rises < 2) rise_cyc[rises] = c;
        bits32 = {bits32[30:0], b_mosi}; rises++;
      end
      prev_sclk = b_sclk;
      if (b_busy) busy_cyc++;
      if (b_ready && b_valid) begin
        if (nacc < 3) acc_cyc[nacc] = c;
        nacc++; just = 1'b1;
      end
    end
    check("gap_accepts", 64'(nacc), 64'(2));
    check("gap_space", 64'(acc_cyc[1] - acc_cyc[0]), 64'(36));
    check("gap_sclk_period", 64'(rise_cyc[1] - rise_cyc[0]), 64'(2));
    check("gap_bits", 64'(bits32), 64'(32'hC3A5_5A3C));
    check("gap_rises", 64'(rises), 64'(32));
    check("gap_busy", 64'(busy_cyc), 64'(70));
    check("gap_wc", 64'(b_wc), 64'(2));

    // Full 2048-word frame on the fast instance
    @(negedge clk); c_data = 16'h8001; c_valid = 1'b1;
    nacc = 0; just = 1'b0; done = 1'b0; npulse = 0; prev_sclk = 1'b0; prev_wc = 0;
    pulse_nacc = -1; pulse_wc = -1; pulse_prev_wc = -1; pulse_prev_sclk = 1'b0; pulse_sclk = 1'b1;
    for (int c = 0; c < 2048 * 33 + 200; c++) begin
      if (c > 0) @(negedge clk);
      if (just) begin
        just = 1'b0;
        if (nacc >= 2048) c_valid = 1'b0;
      end
      if (c_fd) begin
        if (npulse == 0) begin
          pulse_nacc = nacc; pulse_wc = int'(c_wc); pulse_prev_wc = prev_wc;
          pulse_prev_sclk = prev_sclk; pulse_sclk = c_sclk;
        end
        npulse++;
      end
      prev_sclk = c_sclk; prev_wc = int'(c_wc);
      if (nacc >= 2048 && !c_valid && !c_busy && c_ready) begin done = 1'b1; break; end
      if (c_ready && c_valid) begin nacc++; just = 1'b1; end
    end
    check("frame_finished", 64'(done), 64'(1));
    check("frame_accepts", 64'(nacc), 64'(2048));
    check("frame_pulses", 64'(npulse), 64'(1));
    check("frame_pulse_word", 64'(pulse_nacc), 64'(2048));
    check("frame_pulse_wc", 64'(pulse_wc), 64'(0));
    check("frame_wc_before", 64'(pulse_prev_wc), 64'(2047));
    check("frame_pulse_on_fall", 64'({pulse_prev_sclk, pulse_sclk}), 64'(2'b10));
    @(negedge clk);
    check("frame_pulse_width", 64'(c_fd), 64'(0));
    check("frame_wc_final", 64'(c_wc), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_tx.md
SPI_FRAME_TX -- requirements
Module: spi_frame_tx

Interface
REQ-001 Parameter: CLK_DIV, 2, SPI half-period in clk cycles; legal range 1..255.
REQ-002 Parameter: GAP_CYCLES, 0, idle clk cycles inserted after each word with spi_clk low; legal range 0..255.
REQ-003 Parameter: WORDS_PER_FRAME, 2048, words per frame, one complete double-buffer half of the panel controller.
REQ-004 Port: clk  input  1  system clock; the only clock; all state changes on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: in_data  input  16  pixel word; [15:12] red, [11:8] green, [7:4] blue, [3:0] unused but transmitted.
REQ-007 Port: in_valid  input  1  in_data is valid.
REQ-008 Port: in_ready  output  1  block accepts a word this cycle.
REQ-009 Port: spi_clk  output  1  SPI serial clock to the panel controller; idles low.
REQ-010 Port: spi_mosi  output  1  SPI serial data, MSB first.
REQ-011 Port: busy  output  1  high from acceptance of a word until return to IDLE.
REQ-012 Port: frame_done  output  1  one-cycle pulse on completion of the last word of a frame.
REQ-013 Port: word_count  output  11  index of the next word within the frame.

Function
REQ-014 States SHALL be IDLE, SHIFT_LOW, SHIFT_HIGH and GAP.
REQ-015 in_ready SHALL equal (state == IDLE) and not reset; a word is accepted when in_valid and in_ready are both high on a clk edge.
REQ-016 On acceptance: latch in_data into a 16-bit shift register, bit counter = 15, drive spi_mosi = in_data[15], enter SHIFT_LOW.
REQ-017 SHIFT_LOW: spi_clk = 0 for CLK_DIV cycles, then enter SHIFT_HIGH.
REQ-018 SHIFT_HIGH: spi_clk = 1 for CLK_DIV cycles; the slave samples spi_mosi on the rising edge, so spi_mosi SHALL be stable throughout SHIFT_HIGH.
REQ-019 At the end of SHIFT_HIGH with bit counter > 0: decrement the counter, drive the next lower bit on spi_mosi, and enter SHIFT_LOW. spi_mosi changes only coincident with the falling edge.
REQ-020 At the end of SHIFT_HIGH with bit counter = 0: drive spi_clk = 0 and spi_mosi = 0, and update word_count; then enter GAP if GAP_CYCLES > 0, else IDLE.
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles with spi_clk = 0, then enter IDLE.
REQ-022 Each word SHALL produce exactly 16 spi_clk rising edges; the word occupies 32*CLK_DIV cycles from acceptance to the final falling edge.
REQ-023 The minimum word period SHALL be 32*CLK_DIV + GAP_CYCLES + 1 cycles (one IDLE cycle between words).
REQ-024 in_valid and in_data SHALL be ignored outside IDLE; a word is never lost or duplicated.
REQ-025 word_count SHALL increment by 1 per completed word and wrap from WORDS_PER_FRAME-1 to 0.
REQ-026 frame_done SHALL pulse high for one cycle in the same cycle that word_count wraps to 0.
REQ-027 busy SHALL be high in SHIFT_LOW, SHIFT_HIGH and GAP, and low in IDLE.
REQ-028 There is no chip-select; word framing relies only on the slave's bit count. The bit count SHALL therefore never be truncated except by reset.
REQ-029 With in_valid held low, spi_clk SHALL remain low with no edges.

Reset
REQ-030 Reset SHALL force, asynchronously: state IDLE, spi_clk 0, spi_mosi 0, busy 0, frame_done 0, word_count 0, shift register 0, bit counter 0.
REQ-031 Reset mid-word SHALL discard the partial word. The first word after release SHALL start again at bit 15; the panel controller must be reset together with this block to resynchronise.
REQ-032 in_ready SHALL be 0 while reset is high and 1 in the first cycle after release.

Verification (CLK_DIV=2, GAP_CYCLES=0 unless stated)
REQ-033 Single word 0xA5F0 -> 16 rising edges; spi_mosi sampled at those edges = 1010_0101_1111_0000; busy high 64 cycles; word_count 0->1.
REQ-034 in_valid held high with words 0x1111, 0x2222, 0x3333 -> each accepted exactly once; 65-cycle spacing between acceptances; word_count 1, 2, 3.
REQ-035 Send 2048 words -> exactly one frame_done pulse, coincident with the final falling edge of word 2048; word_count returns to 0; no pulse after word 2047.
REQ-036 Reset asserted during SHIFT_HIGH of bit 7 -> spi_clk and spi_mosi go 0 without waiting for a clk edge; word_count 0; the next word transmits all 16 bits from bit 15.
REQ-037 CLK_DIV=1, GAP_CYCLES=3, two back-to-back words -> spi_clk period 2 cycles; 3 gap cycles plus 1 IDLE cycle between words; acceptance spacing 36 cycles.
REQ-038 in_valid low for 500 cycles after reset -> no spi_clk edges; busy 0; in_ready 1.
